// File: rtl/sine_cfg_i2c_target.sv
// I2C target for the sine generator: byte-addressed shadow registers that are committed atomically on STOP.
// SDA changes one clk after a synchronized SCL fall; the commit and the upd_o pulse land one clk after STOP is seen.
module sine_cfg_i2c_target #(
    parameter logic [6:0] ADDR        = 7'h2A,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] ID_VAL      = 8'h5A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_oe,
    output logic [15:0] freq_o,
    output logic [7:0]  amp_o,
    output logic        gen_en_o,
    output logic        upd_o,
    output logic        busy_o
);
    typedef enum logic [3:0] {
        ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_PTR, ST_PTR_ACK,
        ST_WDATA, ST_WDATA_ACK, ST_RDATA, ST_RACK
    } state_t;

    state_t state_q, state_d;
    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic        scl_d, sda_d, scl_s, sda_s;
    logic        scl_rise, scl_fall, start_c, stop_c;
    logic [3:0]  cnt;
    logic [7:0]  sh, ptr, rd_addr, rd_byte;
    logic [15:0] freq_sh;
    logic [7:0]  amp_sh;
    logic        en_sh, dirty, sda_oe_d, addr_match;

    // Sync flops reset to 1 so the idle bus never looks like a START
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    assign scl_s      = scl_sync[SYNC_STAGES-1];
    assign sda_s      = sda_sync[SYNC_STAGES-1];
    assign scl_rise   = scl_s & ~scl_d;
    assign scl_fall   = ~scl_s & scl_d;
    assign start_c    = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_c     = scl_s & scl_d & ~sda_d & sda_s;
    assign addr_match = (sh[7:1] == ADDR);

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // cnt counts SCL rises: 8 closes a byte, 9 closes its ACK slot
    always_comb begin
        state_d = state_q;
        if (start_c)
            state_d = ST_ADDR;
        else if (stop_c)
            state_d = ST_IDLE;
        else if (scl_fall) begin
            case (state_q)
                ST_ADDR:      if (cnt == 4'd8) state_d = addr_match ? ST_ADDR_ACK : ST_IDLE;
                ST_ADDR_ACK:  if (cnt == 4'd9) state_d = sh[0] ? ST_RDATA : ST_PTR;
                ST_PTR:       if (cnt == 4'd8) state_d = ST_PTR_ACK;
                ST_PTR_ACK:   if (cnt == 4'd9) state_d = ST_WDATA;
                ST_WDATA:     if (cnt == 4'd8) state_d = ST_WDATA_ACK;
                ST_WDATA_ACK: if (cnt == 4'd9) state_d = ST_WDATA;
                ST_RDATA:     if (cnt == 4'd8) state_d = ST_RACK;
                ST_RACK:      if (cnt == 4'd9) state_d = sh[0] ? ST_IDLE : ST_RDATA;
                default:      state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        rd_addr = (state_q == ST_RACK) ? ptr + 8'd1 : ptr;
        case (rd_addr)
            8'h00:   rd_byte = {7'd0, en_sh};
            8'h01:   rd_byte = freq_sh[7:0];
            8'h02:   rd_byte = freq_sh[15:8];
            8'h03:   rd_byte = amp_sh;
            8'h04:   rd_byte = {7'd0, dirty};
            8'h05:   rd_byte = ID_VAL;
            default: rd_byte = 8'h00;
        endcase
    end

    always_comb begin
        sda_oe_d = sda_oe;
        if (start_c || stop_c)
            sda_oe_d = 1'b0;
        else if (scl_fall) begin
            case (state_q)
                ST_ADDR:                  if (cnt == 4'd8) sda_oe_d = addr_match;
                ST_PTR, ST_WDATA:         if (cnt == 4'd8) sda_oe_d = 1'b1;
                ST_ADDR_ACK:              if (cnt == 4'd9) sda_oe_d = sh[0] & ~rd_byte[7];
                ST_PTR_ACK, ST_WDATA_ACK: if (cnt == 4'd9) sda_oe_d = 1'b0;
                ST_RDATA:                 sda_oe_d = (cnt == 4'd8) ? 1'b0 : ~sh[6];
                ST_RACK:                  if (cnt == 4'd9) sda_oe_d = ~sh[0] & ~rd_byte[7];
                default:                  sda_oe_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sda_oe   <= 1'b0;
            upd_o    <= 1'b0;
            busy_o   <= 1'b0;
            cnt      <= 4'd0;
            sh       <= 8'h00;
            ptr      <= 8'h00;
            freq_sh  <= 16'h0000;
            amp_sh   <= 8'h00;
            en_sh    <= 1'b0;
            dirty    <= 1'b0;
            freq_o   <= 16'h0000;
            amp_o    <= 8'h00;
            gen_en_o <= 1'b0;
        end else begin
            sda_oe <= sda_oe_d;
            upd_o  <= 1'b0;

            if (start_c || state_d == ST_IDLE)  cnt <= 4'd0;
            else if (scl_rise)                  cnt <= cnt + 4'd1;
            else if (scl_fall && cnt == 4'd9)   cnt <= 4'd0;

            // In RACK the master's ACK bit lands in sh[0]
            if (scl_rise && (state_q == ST_ADDR || state_q == ST_PTR ||
                             state_q == ST_WDATA || state_q == ST_RACK))
                sh <= {sh[6:0], sda_s};
            else if (scl_fall && state_q == ST_RDATA && cnt != 4'd8)
                sh <= {sh[6:0], 1'b0};
            else if (scl_fall && cnt == 4'd9 &&
                     ((state_q == ST_ADDR_ACK && sh[0]) || (state_q == ST_RACK && !sh[0])))
                sh <= rd_byte;

            if (scl_fall && cnt == 4'd8 && state_q == ST_PTR)
                ptr <= sh;
            else if ((scl_fall && cnt == 4'd8 && state_q == ST_WDATA) ||
                     (scl_fall && cnt == 4'd9 && state_q == ST_RACK && !sh[0]))
                ptr <= ptr + 8'd1;

            if (scl_fall && cnt == 4'd8 && state_q == ST_WDATA && ptr < 8'd4) begin
                case (ptr[1:0])
                    2'd0: en_sh          <= sh[0];
                    2'd1: freq_sh[7:0]   <= sh;
                    2'd2: freq_sh[15:8]  <= sh;
                    2'd3: amp_sh         <= sh;
                endcase
                dirty <= 1'b1;
            end

            if (stop_c && dirty) begin
                freq_o   <= freq_sh;
                amp_o    <= amp_sh;
                gen_en_o <= en_sh;
                upd_o    <= 1'b1;
                dirty    <= 1'b0;
            end

            if (state_d == ST_IDLE)
                busy_o <= 1'b0;
            else if (state_q == ST_ADDR && state_d == ST_ADDR_ACK)
                busy_o <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sine_cfg_i2c_target.sv
// Bit-banged I2C master driving sine_cfg_i2c_target, checked against a register-level model of the target.
module tb_sine_cfg_i2c_target;
    localparam int Q = 5;

    logic clk = 1'b0, rst = 1'b1, scl_m = 1'b1, sda_m = 1'b1;
    logic sda_oe, gen_en_o, upd_o, busy_o;
    logic [15:0] freq_o;
    logic [7:0]  amp_o;
    wire sda_line = sda_m & ~sda_oe;

    int chk_cnt = 0, pass_cnt = 0, upd_cnt = 0, oe_cnt = 0;

    logic [7:0]  m_sh [4];
    logic        m_dirty, m_en;
    logic [7:0]  m_ptr, m_amp;
    logic [15:0] m_freq;
    logic [7:0]  wq[$], rq[$], eq[$];

    always #5 clk = ~clk;

    sine_cfg_i2c_target #(.ADDR(7'h2A), .SYNC_STAGES(2), .ID_VAL(8'h5A)) dut (
        .clk(clk), .rst(rst), .scl_i(scl_m), .sda_i(sda_line), .sda_oe(sda_oe),
        .freq_o(freq_o), .amp_o(amp_o), .gen_en_o(gen_en_o), .upd_o(upd_o), .busy_o(busy_o)
    );

    always @(posedge clk) begin
        if (upd_o)  upd_cnt++;
        if (sda_oe) oe_cnt++;
    end

    task automatic m_reset;
        for (int i = 0; i < 4; i++) m_sh[i] = 8'h00;
        m_dirty = 1'b0; m_en = 1'b0; m_ptr = 8'h00; m_amp = 8'h00; m_freq = 16'h0000;
    endtask

    function automatic logic [7:0] m_read(input logic [7:0] p);
        if (p < 8'd4)  return m_sh[p[1:0]];
        if (p == 8'd4) return {7'd0, m_dirty};
        if (p == 8'd5) return 8'h5A;
        return 8'h00;
    endfunction

    task automatic m_write(input logic [7:0] d);
        if (m_ptr < 8'd4) begin
            m_sh[m_ptr[1:0]] = (m_ptr == 8'd0) ? {7'd0, d[0]} : d;
            m_dirty = 1'b1;
        end
        m_ptr = m_ptr + 8'd1;
    endtask

    function automatic int m_stop();
        if (!m_dirty) return 0;
        m_freq = {m_sh[2], m_sh[1]};
        m_amp = m_sh[3];
        m_en = m_sh[0][0];
        m_dirty = 1'b0;
        return 1;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_start;
        sda_m = 1'b1; tick(Q); scl_m = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q); scl_m = 1'b0; tick(Q);
    endtask

    task automatic bus_stop;
        sda_m = 1'b0; tick(Q); scl_m = 1'b1; tick(Q); sda_m = 1'b1; tick(Q);
    endtask

    task automatic clk_bit(input logic b, output logic s);
        sda_m = b; tick(Q); scl_m = 1'b1; tick(Q);
        s = sda_line; tick(Q); scl_m = 1'b0; tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
        clk_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, s);
            b[i] = s;
        end
        clk_bit(nack, s);
    endtask

    task automatic wr_txn(input logic [7:0] p, output int missed);
        logic a;
        missed = 0;
        bus_start;
        write_byte({7'h2A, 1'b0}, a); if (!a) missed++;
        write_byte(p, a);             if (!a) missed++;
        m_ptr = p;
        foreach (wq[i]) begin
            write_byte(wq[i], a); if (!a) missed++;
            m_write(wq[i]);
        end
    endtask

    task automatic rd_txn(input int n, output int missed);
        logic a;
        logic [7:0] b;
        missed = 0;
        rq.delete(); eq.delete();
        bus_start;
        write_byte({7'h2A, 1'b1}, a); if (!a) missed++;
        for (int k = 0; k < n; k++) begin
            read_byte(k == n - 1, b);
            rq.push_back(b);
            eq.push_back(m_read(m_ptr));
            if (k != n - 1) m_ptr = m_ptr + 8'd1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; tick(4); rst = 1'b0; m_reset(); tick(4);
        chk_cnt++;
        if ({sda_oe, upd_o, busy_o} !== 3'b000) $display("FAIL reset_ctl got %b exp 000", {sda_oe, upd_o, busy_o});
        else pass_cnt++;
        chk_cnt++;
        if ({freq_o, amp_o, gen_en_o} !== 25'd0) $display("FAIL reset_out got %h exp 0", {freq_o, amp_o, gen_en_o});
        else pass_cnt++;
    endtask

    task automatic test_write_commit;
        int missed, u0, eu;
        wq = '{8'h34, 8'h12, 8'h80};
        wr_txn(8'h01, missed);
        chk_cnt++;
        if (missed !== 0) $display("FAIL wc_acks got %0d missing exp 0", missed); else pass_cnt++;
        chk_cnt++;
        if (busy_o !== 1'b1) $display("FAIL wc_busy got %b exp 1", busy_o); else pass_cnt++;
        chk_cnt++;
        if (freq_o !== m_freq) $display("FAIL wc_prestop got %h exp %h", freq_o, m_freq); else pass_cnt++;
        u0 = upd_cnt; eu = m_stop(); bus_stop; tick(4);
        chk_cnt++;
        if (upd_cnt - u0 !== eu) $display("FAIL wc_upd got %0d exp %0d", upd_cnt - u0, eu); else pass_cnt++;
        chk_cnt++;
        if ({freq_o, amp_o, gen_en_o} !== {m_freq, m_amp, m_en})
            $display("FAIL wc_out got %h exp %h", {freq_o, amp_o, gen_en_o}, {m_freq, m_amp, m_en});
        else pass_cnt++;
        chk_cnt++;
        if (busy_o !== 1'b0) $display("FAIL wc_busy_end got %b exp 0", busy_o); else pass_cnt++;
    endtask

    task automatic test_id_read;
        int missed, m2, u0, eu;
        wq.delete();
        wr_txn(8'h05, missed);
        rd_txn(1, m2);
        chk_cnt++;
        if (missed + m2 !== 0) $display("FAIL id_acks got %0d missing exp 0", missed + m2); else pass_cnt++;
        chk_cnt++;
        if (rq[0] !== eq[0]) $display("FAIL id_byte got %h exp %h", rq[0], eq[0]); else pass_cnt++;
        chk_cnt++;
        if ({sda_oe, busy_o} !== 2'b00) $display("FAIL id_release got %b exp 00", {sda_oe, busy_o}); else pass_cnt++;
        u0 = upd_cnt; eu = m_stop(); bus_stop; tick(4);
        chk_cnt++;
        if (upd_cnt - u0 !== eu) $display("FAIL id_upd got %0d exp %0d", upd_cnt - u0, eu); else pass_cnt++;
    endtask

    task automatic test_wrong_addr;
        logic a, a2;
        int o0, u0;
        o0 = oe_cnt; u0 = upd_cnt;
        bus_start;
        write_byte({7'h2B, 1'b0}, a);
        write_byte(8'h01, a2);
        chk_cnt++;
        if ({a, a2} !== 2'b00) $display("FAIL wa_ack got %b exp 00", {a, a2}); else pass_cnt++;
        chk_cnt++;
        if (busy_o !== 1'b0) $display("FAIL wa_busy got %b exp 0", busy_o); else pass_cnt++;
        bus_stop; tick(4);
        chk_cnt++;
        if (oe_cnt - o0 !== 0) $display("FAIL wa_oe got %0d cycles exp 0", oe_cnt - o0); else pass_cnt++;
        chk_cnt++;
        if (upd_cnt - u0 !== m_stop()) $display("FAIL wa_upd got %0d exp 0", upd_cnt - u0); else pass_cnt++;
        chk_cnt++;
        if ({freq_o, amp_o, gen_en_o} !== {m_freq, m_amp, m_en})
            $display("FAIL wa_out got %h exp %h", {freq_o, amp_o, gen_en_o}, {m_freq, m_amp, m_en});
        else pass_cnt++;
    endtask

    task automatic test_ctrl_status;
        int missed, m2, u0, eu;
        wq = '{8'h01};
        wr_txn(8'h00, missed);
        u0 = upd_cnt; eu = m_stop(); bus_stop; tick(4);
        chk_cnt++;
        if (upd_cnt - u0 !== eu) $display("FAIL cs_upd got %0d exp %0d", upd_cnt - u0, eu); else pass_cnt++;
        chk_cnt++;
        if (gen_en_o !== m_en) $display("FAIL cs_en got %b exp %b", gen_en_o, m_en); else pass_cnt++;
        wq.delete();
        wr_txn(8'h04, missed);
        rd_txn(1, m2);
        bus_stop; tick(4);
        chk_cnt++;
        if (missed + m2 !== 0) $display("FAIL cs_acks got %0d missing exp 0", missed + m2); else pass_cnt++;
        chk_cnt++;
        if (rq[0] !== eq[0]) $display("FAIL cs_status got %h exp %h", rq[0], eq[0]); else pass_cnt++;
    endtask

    task automatic test_ptr_wrap;
        int missed, m2, u0, eu;
        wq.delete();
        wr_txn(8'hFE, missed);
        rd_txn(3, m2);
        u0 = upd_cnt; eu = m_stop(); bus_stop; tick(4);
        for (int k = 0; k < 3; k++) begin
            chk_cnt++;
            if (rq[k] !== eq[k]) $display("FAIL wrap_rd[%0d] got %h exp %h", k, rq[k], eq[k]); else pass_cnt++;
        end
        chk_cnt++;
        if (upd_cnt - u0 !== eu) $display("FAIL wrap_upd got %0d exp %0d", upd_cnt - u0, eu); else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        int missed, m2, u0;
        logic s;
        logic [7:0] d;
        wq.delete();
        wr_txn(8'h02, missed);
        d = 8'hAB;
        for (int i = 7; i >= 0; i--) clk_bit(d[i], s);
        sda_m = 1'b1; tick(Q); scl_m = 1'b1; tick(Q);
        chk_cnt++;
        if (sda_oe !== 1'b1) $display("FAIL rm_ack_drive got %b exp 1", sda_oe); else pass_cnt++;
        rst = 1'b1; tick(1);
        chk_cnt++;
        if (sda_oe !== 1'b0) $display("FAIL rm_release got %b exp 0", sda_oe); else pass_cnt++;
        rst = 1'b0; m_reset();
        scl_m = 1'b0; tick(Q);
        chk_cnt++;
        if ({freq_o, amp_o, gen_en_o} !== {m_freq, m_amp, m_en})
            $display("FAIL rm_out got %h exp %h", {freq_o, amp_o, gen_en_o}, {m_freq, m_amp, m_en});
        else pass_cnt++;
        u0 = upd_cnt; bus_stop; tick(4);
        chk_cnt++;
        if (upd_cnt - u0 !== m_stop()) $display("FAIL rm_upd got %0d exp 0", upd_cnt - u0); else pass_cnt++;
        wr_txn(8'h04, missed);
        rd_txn(1, m2);
        bus_stop; tick(4);
        chk_cnt++;
        if (rq[0] !== eq[0]) $display("FAIL rm_dirty got %h exp %h", rq[0], eq[0]); else pass_cnt++;
    endtask

    task automatic test_random;
        int missed, m2, u0, eu, n;
        for (int it = 0; it < 6; it++) begin
            wq.delete();
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) wq.push_back(8'($urandom));
            wr_txn(8'($urandom_range(0, 6)), missed);
            u0 = upd_cnt; eu = m_stop(); bus_stop; tick(4);
            chk_cnt++;
            if (missed !== 0 || upd_cnt - u0 !== eu)
                $display("FAIL rand_wr[%0d] missing %0d upd %0d exp missing 0 upd %0d", it, missed, upd_cnt - u0, eu);
            else pass_cnt++;
            chk_cnt++;
            if ({freq_o, amp_o, gen_en_o} !== {m_freq, m_amp, m_en})
                $display("FAIL rand_out[%0d] got %h exp %h", it, {freq_o, amp_o, gen_en_o}, {m_freq, m_amp, m_en});
            else pass_cnt++;
            wq.delete();
            wr_txn(8'($urandom_range(0, 7)), missed);
            rd_txn($urandom_range(1, 3), m2);
            bus_stop; tick(4);
            foreach (rq[k]) begin
                chk_cnt++;
                if (rq[k] !== eq[k]) $display("FAIL rand_rd[%0d.%0d] got %h exp %h", it, k, rq[k], eq[k]);
                else pass_cnt++;
            end
        end
    endtask

    initial begin
        test_reset;
        test_write_commit;
        test_id_read;
        test_wrong_addr;
        test_ctrl_status;
        test_ptr_wrap;
        test_reset_mid;
        test_random;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
